vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Free-running VGA timing generator for the 640x480 @ 60 Hz pong display. Produces the pixel/line coordinates and active-low horizontal/vertical sync pulses consumed directly by the image and rectangle drawing stages (`i_display_x_pos`, `i_display_y_pos`, `i_hSync`, `i_vSync`). It also produces a one-cycle frame-start strobe so game logic can update object positions between frames.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- i_CLK  in  1  25 MHz pixel clock; one pixel per cycle
- i_RST  in  1  reset, asynchronous, active-high
- o_display_x_pos  out  10  horizontal count, 0..H_TOTAL-1
- o_display_y_pos  out  10  vertical count, 0..V_TOTAL-1
- o_hSync  out  1  horizontal sync, active-low
- o_vSync  out  1  vertical sync, active-low
- o_active  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- o_frame_start  out  1  one-cycle strobe at the start of each new frame
- o_frame_count  out  16  frame counter (see Configuration)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤ 1024; counters are 10-bit unsigned.
- Horizontal counter increments by 1 every cycle. At H_TOTAL-1 it wraps to 0, and the vertical counter increments in the same cycle.
- Vertical counter wraps from V_TOTAL-1 to 0 only when the horizontal counter also wraps (x=799, y=524 -> x=0, y=0).
- o_hSync = 0 iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults); otherwise 1.
- o_vSync = 0 iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC (490..491 at defaults); otherwise 1. vSync is asserted for whole lines (x = 0..799).
- o_frame_start = 1 for exactly the cycle in which outputs show (0,0) after a wrap from (799,524). It is not asserted on the first (0,0) following reset release.
- Reset values, applied asynchronously while i_RST=1: x=0, y=0, o_hSync=1, o_vSync=1, o_active=1 (consistent with (0,0)), o_frame_start=0, o_frame_count=0.
- Reset mid-frame: all outputs return to their reset values immediately. Counting resumes from (0,0) on the first i_CLK edge after i_RST falls. No frame_start is issued for that frame.

## Timing
- All outputs are registered. o_hSync, o_vSync, o_active and o_frame_start are computed from the next-state counter values, so every output refers to the same (x,y) in the same cycle. Relative alignment has zero skew.
- Downstream stages add their own one-cycle register on RGB and re-register the syncs. This block must not add delay between the coordinates and the syncs.
- Line period is 800 cycles. Frame period is 420,000 cycles.
- Once reset is released there is no stall or enable; the block never stops counting.

## Configuration
- Macro `VGA_SYNC_FRAME_CNT_EN`.
- Defined: o_frame_count increments by 1 in the same cycle o_frame_start is asserted, and wraps 65535 -> 0.
- Not defined: no counter is built, and o_frame_count is tied to 16'd0.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold i_RST high for 5 cycles, then release. Required: x=0, y=0, hSync=1, vSync=1, active=1, frame_start=0 during reset. x=1 one cycle after the first edge.
- Hsync edges: observe line 0. Required: hSync=1 at x=655, 0 at x=656 and 751, 1 at x=752. active=0 from x=640.
- Line wrap: at x=799, y=10, the next cycle must show x=0, y=11, with frame_start=0.
- Vsync: vSync=1 on line 489, 0 for all of lines 490 and 491, and 1 from line 492, x=0.
- Frame wrap: (799,524) -> (0,0) with frame_start=1 for exactly one cycle. The next frame_start follows 420,000 cycles later. With the macro defined, frame_count goes 0 -> 1 -> 2 over two frames.
- Mid-frame reset: assert i_RST asynchronously at (300,200) between clock edges. Outputs must return to their reset values without waiting for a clock edge. After release the sequence restarts at (0,0), with no frame_start until the first wrap.

Source files
------------

// File: rtl/vga_sync_gen_if.sv
// Output bundle of the VGA timing generator: coordinates, syncs, active flag,
// frame-start strobe and frame counter, with master (generator) and slave (consumer) views.
interface vga_sync_gen_if;
    logic [9:0]  o_display_x_pos;
    logic [9:0]  o_display_y_pos;
    logic        o_hSync;
    logic        o_vSync;
    logic        o_active;
    logic        o_frame_start;
    logic [15:0] o_frame_count;

    modport master (
        output o_display_x_pos,
        output o_display_y_pos,
        output o_hSync,
        output o_vSync,
        output o_active,
        output o_frame_start,
        output o_frame_count
    );

    modport slave (
        input o_display_x_pos,
        input o_display_y_pos,
        input o_hSync,
        input o_vSync,
        input o_active,
        input o_frame_start,
        input o_frame_count
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Free-running 640x480@60 VGA timing generator with registered, zero-skew outputs.
// Optional frame counter is built only when VGA_SYNC_FRAME_CNT_EN is defined.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic           i_CLK,
    input  logic           i_RST,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       h_wrap;
    logic       v_wrap;
    logic       h_sync_q;
    logic       v_sync_q;
    logic       active_q;
    logic       frame_start_q;

    always_comb begin
        h_wrap = (x_pos == H_LAST);
        v_wrap = (y_pos == V_LAST);
        x_next = h_wrap ? 10'd0 : x_pos + 10'd1;
        y_next = y_pos;
        if (h_wrap) begin
            y_next = v_wrap ? 10'd0 : y_pos + 10'd1;
        end
    end

    // Every flag is decoded from the next coordinates so it lands in the same cycle as them.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            x_pos         <= 10'd0;
            y_pos         <= 10'd0;
            h_sync_q      <= 1'b1;
            v_sync_q      <= 1'b1;
            active_q      <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            x_pos         <= x_next;
            y_pos         <= y_next;
            h_sync_q      <= !((x_next >= HS_START) && (x_next < HS_END));
            v_sync_q      <= !((y_next >= VS_START) && (y_next < VS_END));
            active_q      <= (x_next < H_ACT_END) && (y_next < V_ACT_END);
            frame_start_q <= h_wrap && v_wrap;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_count_q;

    // Advances on the same edge that raises the frame-start strobe.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            frame_count_q <= 16'd0;
        end else if (h_wrap && v_wrap) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign vga.o_frame_count = frame_count_q;
`else
    assign vga.o_frame_count = 16'd0;
`endif

    assign vga.o_display_x_pos = x_pos;
    assign vga.o_display_y_pos = y_pos;
    assign vga.o_hSync         = h_sync_q;
    assign vga.o_vSync         = v_sync_q;
    assign vga.o_active        = active_q;
    assign vga.o_frame_start   = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: dut_a uses the 640x480 timing for horizontal and line checks,
// dut_b a shrunken 32x19 timing (hsync 20..27, vsync lines 14..15) so whole frames fit a short run.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   errors = 0;
    int   checks = 0;

`ifdef VGA_SYNC_FRAME_CNT_EN
    localparam int FC_EN = 1;
`else
    localparam int FC_EN = 0;
`endif

    always #20 clk = ~clk;

    vga_sync_gen_if ifa ();
    vga_sync_gen_if ifb ();

    vga_sync_gen dut_a (
        .i_CLK (clk),
        .i_RST (rst_a),
        .vga   (ifa)
    );

    vga_sync_gen #(
        .H_ACTIVE (16), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (12), .V_FP (2), .V_SYNC (2), .V_BP (3)
    ) dut_b (
        .i_CLK (clk),
        .i_RST (rst_b),
        .vga   (ifb)
    );

    // Packed view {x, y, hSync, vSync, active, frame_start}.
    function automatic logic [23:0] obs_a();
        return {ifa.o_display_x_pos, ifa.o_display_y_pos, ifa.o_hSync, ifa.o_vSync,
                ifa.o_active, ifa.o_frame_start};
    endfunction

    function automatic logic [23:0] obs_b();
        return {ifb.o_display_x_pos, ifb.o_display_y_pos, ifb.o_hSync, ifb.o_vSync,
                ifb.o_active, ifb.o_frame_start};
    endfunction

    function automatic logic [23:0] exp_v(input int x, input int y, input bit hs, input bit vs,
                                          input bit act, input bit fs);
        return {10'(x), 10'(y), hs, vs, act, fs};
    endfunction

    task automatic seek_a(input int tx, input int ty, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ifa.o_display_x_pos == 10'(tx) && ifa.o_display_y_pos == 10'(ty)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic seek_b(input int tx, input int ty, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ifb.o_display_x_pos == 10'(tx) && ifb.o_display_y_pos == 10'(ty)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [23:0] e;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (5) @(negedge clk);
        e = exp_v(0, 0, 1, 1, 1, 0);
        checks++;
        if (obs_a() !== e) begin
            errors++;
            $display("[TB] FAIL reset_a: got %h expected %h", obs_a(), e);
        end
        checks++;
        if (ifa.o_frame_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_fc: got %0d expected 0", ifa.o_frame_count);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        e = exp_v(1, 0, 1, 1, 1, 0);
        checks++;
        if (obs_a() !== e) begin
            errors++;
            $display("[TB] FAIL first_edge_a: got %h expected %h", obs_a(), e);
        end
        e = exp_v(1, 0, 1, 1, 1, 0);
        checks++;
        if (obs_b() !== e) begin
            errors++;
            $display("[TB] FAIL first_edge_b: got %h expected %h", obs_b(), e);
        end
    endtask

    task automatic test_hsync();
        bit ok;
        int xs[6] = '{639, 640, 655, 656, 751, 752};
        bit hs[6] = '{1, 1, 1, 0, 0, 1};
        bit ac[6] = '{1, 0, 0, 0, 0, 0};
        logic [23:0] e;
        for (int i = 0; i < 6; i++) begin
            seek_a(xs[i], 0, 900, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL hsync_seek_%0d: got timeout expected x=%0d", xs[i], xs[i]);
            end
            e = exp_v(xs[i], 0, hs[i], 1, ac[i], 0);
            checks++;
            if (obs_a() !== e) begin
                errors++;
                $display("[TB] FAIL hsync_x%0d: got %h expected %h", xs[i], obs_a(), e);
            end
        end
    endtask

    task automatic test_line_wrap();
        bit ok;
        logic [23:0] e;
        seek_a(799, 10, 10000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL line_wrap_seek: got timeout expected (799,10)");
        end
        e = exp_v(799, 10, 1, 1, 0, 0);
        checks++;
        if (obs_a() !== e) begin
            errors++;
            $display("[TB] FAIL line_end: got %h expected %h", obs_a(), e);
        end
        @(negedge clk);
        e = exp_v(0, 11, 1, 1, 1, 0);
        checks++;
        if (obs_a() !== e) begin
            errors++;
            $display("[TB] FAIL line_wrap: got %h expected %h", obs_a(), e);
        end
    endtask

    task automatic test_vsync();
        bit ok;
        int xs[7] = '{15, 16, 31, 0, 31, 0, 0};
        int ys[7] = '{11, 11, 13, 14, 15, 15, 16};
        bit vs[7] = '{1, 1, 1, 0, 0, 0, 1};
        bit ac[7] = '{1, 0, 0, 0, 0, 0, 0};
        logic [23:0] e;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        for (int i = 0; i < 7; i++) begin
            seek_b(xs[i], ys[i], 700, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL vsync_seek_%0d: got timeout expected (%0d,%0d)", i, xs[i], ys[i]);
            end
            e = exp_v(xs[i], ys[i], 1, vs[i], ac[i], 0);
            checks++;
            if (obs_b() !== e) begin
                errors++;
                $display("[TB] FAIL vsync_%0d: got %h expected %h", i, obs_b(), e);
            end
        end
    endtask

    task automatic test_frame_wrap();
        bit ok;
        int n;
        logic [23:0] e;
        seek_b(31, 18, 700, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL frame_seek: got timeout expected (31,18)");
        end
        @(negedge clk);
        e = exp_v(0, 0, 1, 1, 1, 1);
        checks++;
        if (obs_b() !== e) begin
            errors++;
            $display("[TB] FAIL frame_wrap: got %h expected %h", obs_b(), e);
        end
        checks++;
        if (ifb.o_frame_count !== 16'(FC_EN)) begin
            errors++;
            $display("[TB] FAIL frame_count_1: got %0d expected %0d", ifb.o_frame_count, FC_EN);
        end
        @(negedge clk);
        e = exp_v(1, 0, 1, 1, 1, 0);
        checks++;
        if (obs_b() !== e) begin
            errors++;
            $display("[TB] FAIL frame_strobe_len: got %h expected %h", obs_b(), e);
        end
        n = 1;
        while (n < 700 && ifb.o_frame_start !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 608) begin
            errors++;
            $display("[TB] FAIL frame_period: got %0d expected 608", n);
        end
        checks++;
        if (ifb.o_frame_count !== 16'(2 * FC_EN)) begin
            errors++;
            $display("[TB] FAIL frame_count_2: got %0d expected %0d", ifb.o_frame_count, 2 * FC_EN);
        end
    endtask

    task automatic test_mid_frame_reset();
        bit ok;
        int fs_seen;
        logic [23:0] e;
        seek_b(22, 14, 700, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL midreset_seek: got timeout expected (22,14)");
        end
        e = exp_v(22, 14, 0, 0, 0, 0);
        checks++;
        if (obs_b() !== e) begin
            errors++;
            $display("[TB] FAIL midreset_before: got %h expected %h", obs_b(), e);
        end
        #5 rst_b = 1'b1;
        #1;
        e = exp_v(0, 0, 1, 1, 1, 0);
        checks++;
        if (obs_b() !== e) begin
            errors++;
            $display("[TB] FAIL midreset_async: got %h expected %h", obs_b(), e);
        end
        checks++;
        if (ifb.o_frame_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midreset_fc: got %0d expected 0", ifb.o_frame_count);
        end
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        e = exp_v(1, 0, 1, 1, 1, 0);
        checks++;
        if (obs_b() !== e) begin
            errors++;
            $display("[TB] FAIL midreset_restart: got %h expected %h", obs_b(), e);
        end
        fs_seen = 0;
        for (int i = 0; i < 700; i++) begin
            if (ifb.o_display_x_pos == 10'd31 && ifb.o_display_y_pos == 10'd18) break;
            if (ifb.o_frame_start === 1'b1) fs_seen++;
            @(negedge clk);
        end
        checks++;
        if (fs_seen != 0) begin
            errors++;
            $display("[TB] FAIL midreset_no_strobe: got %0d strobes expected 0", fs_seen);
        end
        @(negedge clk);
        e = exp_v(0, 0, 1, 1, 1, 1);
        checks++;
        if (obs_b() !== e) begin
            errors++;
            $display("[TB] FAIL midreset_wrap: got %h expected %h", obs_b(), e);
        end
        checks++;
        if (ifb.o_frame_count !== 16'(FC_EN)) begin
            errors++;
            $display("[TB] FAIL midreset_fc_wrap: got %0d expected %0d", ifb.o_frame_count, FC_EN);
        end
    endtask

    initial begin
        test_reset();
        test_hsync();
        test_line_wrap();
        test_vsync();
        test_frame_wrap();
        test_mid_frame_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
